// File: rtl/word_serializer.sv
// Parallel-to-serial unloader: captures {flag, data} and shifts it out LSB first,
// one bit per accepted handshake, with a one-cycle done pulse after the flag bit.
module word_serializer #(
  parameter int unsigned size = 2,
  parameter int unsigned CW   = $clog2(size + 2)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [size-1:0] inputData,
  input  logic            inputData_,
  input  logic            outReady,
  output logic            outBit,
  output logic            outValid,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [size:0]   r_sr;
  logic [size:0]   w_sr_nxt;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;
  logic            r_out_bit;
  logic            r_out_valid;
  logic            r_busy;
  logic            r_done;
  logic            w_hs;

  assign w_hs = (r_state == S_SHIFT) & outReady;

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_sr_nxt    = {inputData_, inputData};
          w_count_nxt = '0;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_hs) begin
          w_sr_nxt    = r_sr >> 1;
          w_count_nxt = r_count + CW'(1);
          if (r_count == CW'(size)) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr        <= '0;
      r_count     <= '0;
      r_out_bit   <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_sr        <= w_sr_nxt;
      r_count     <= w_count_nxt;
      r_out_valid <= (w_state_nxt == S_SHIFT);
      r_out_bit   <= (w_state_nxt == S_SHIFT) & w_sr_nxt[0];
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  assign outBit   = r_out_bit;
  assign outValid = r_out_valid;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: queue-based frame model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_word_serializer;

  localparam int unsigned SIZE = 4;
  localparam int unsigned CW   = $clog2(SIZE + 2);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [SIZE-1:0] data = '0;
  logic            flag = 1'b0;
  logic            ready = 1'b0;
  logic            out_bit, out_valid, busy, done;

  word_serializer #(.size(SIZE), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .inputData(data), .inputData_(flag),
    .outReady(ready), .outBit(out_bit), .outValid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: a frame is the queue of bits still to be sent, then one done cycle.
  bit m_q[$];
  bit m_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_q.size() != 0) begin
      if (ready) begin
        m_q.delete(0);
        if (m_q.size() == 0) m_done = 1'b1;
      end
    end else if (start) begin
      for (int i = 0; i < int'(SIZE); i++) m_q.push_back(data[i]);
      m_q.push_back(flag);
    end
  end

  logic [15:0] acc;
  int          acc_n;
  int          hs_q[$];
  int          rise_q[$];
  int          done_n;
  int          done_cyc;
  int          start_cyc;
  logic        prev_v = 1'b0;
  logic        ev, eb;

  // Per-cycle comparison against the model, plus event recording for scenarios.
  always @(negedge clk) begin
    cyc++;
    ev = (m_q.size() != 0);
    eb = ev ? m_q[0] : 1'b0;
    chk("outValid", 32'(out_valid), 32'(ev));
    chk("outBit",   32'(out_bit),   32'(eb));
    chk("busy",     32'(busy),      32'(ev | m_done));
    chk("done",     32'(done),      32'(m_done));
    if (out_valid && ready && !rst) begin
      if (acc_n < 16) acc[acc_n] = out_bit;
      acc_n++;
      hs_q.push_back(cyc);
    end
    if (out_valid && !prev_v) rise_q.push_back(cyc);
    prev_v = out_valid;
    if (done) begin
      done_n++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    if (start && start_cyc < 0) start_cyc = cyc;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    acc = '0;
    acc_n = 0;
    hs_q.delete();
    rise_q.delete();
    done_n = 0;
    done_cyc = -1;
    start_cyc = -1;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int k;
    k = 0;
    while (done_n == 0 && k < budget) begin
      step();
      k++;
    end
    chk({nm, "_done_seen"}, 32'(done_n != 0), 32'(1));
  endtask

  task automatic send(input logic [SIZE-1:0] d, input logic f);
    data  = d;
    flag  = f;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    // Reset with random inputs.
    data = SIZE'($urandom); flag = 1'($urandom); start = 1'($urandom); ready = 1'($urandom);
    step();
    data = SIZE'($urandom); flag = 1'($urandom); start = 1'($urandom); ready = 1'($urandom);
    step();
    chk("rst_outValid", 32'(out_valid), 32'(0));
    chk("rst_outBit",   32'(out_bit),   32'(0));
    chk("rst_busy",     32'(busy),      32'(0));
    chk("rst_done",     32'(done),      32'(0));
    rst = 1'b0; start = 1'b0; ready = 1'b1;
    step();

    // Plain frame.
    clr();
    send(4'b1011, 1'b1);
    wait_done(20, "s2");
    step();
    chk("s2_nbits",   32'(acc_n),               32'(5));
    chk("s2_bits",    32'(acc[4:0]),            32'(5'b11011));
    chk("s2_latency", 32'(done_cyc - start_cyc), 32'(6));
    chk("s2_done_n",  32'(done_n),              32'(1));
    chk("s2_busy0",   32'(busy),                32'(0));

    // Start re-pulsed mid-frame with other data is ignored.
    clr();
    send(4'b1011, 1'b1);
    step();
    send(4'b1111, 1'b0);
    wait_done(20, "s4");
    step();
    chk("s4_nbits",  32'(acc_n),    32'(5));
    chk("s4_bits",   32'(acc[4:0]), 32'(5'b11011));
    chk("s4_done_n", 32'(done_n),   32'(1));

    // Backpressure for three SHIFT cycles.
    clr();
    ready = 1'b0;
    send(4'b0110, 1'b0);
    step(); step(); step();
    chk("s3_stall_valid", 32'(out_valid), 32'(1));
    chk("s3_stall_bit",   32'(out_bit),   32'(0));
    ready = 1'b1;
    wait_done(20, "s3");
    step();
    chk("s3_nbits",   32'(acc_n),                32'(5));
    chk("s3_bits",    32'(acc[4:0]),             32'(5'b00110));
    chk("s3_latency", 32'(done_cyc - start_cyc), 32'(9));

    // Reset after the second accepted bit aborts the frame.
    clr();
    send(4'b0101, 1'b1);
    for (int k = 0; k < 20 && acc_n < 2; k++) step();
    chk("s5_two_bits", 32'(acc_n), 32'(2));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s5_valid0", 32'(out_valid), 32'(0));
    chk("s5_busy0",  32'(busy),      32'(0));
    step(); step(); step();
    chk("s5_no_done", 32'(done_n), 32'(0));
    clr();
    send(4'b1001, 1'b0);
    wait_done(20, "s5b");
    step();
    chk("s5_nbits", 32'(acc_n),    32'(5));
    chk("s5_bits",  32'(acc[4:0]), 32'(5'b01001));

    // Start held high: back-to-back frames.
    clr();
    data = 4'b1100; flag = 1'b1; start = 1'b1;
    for (int k = 0; k < 30 && rise_q.size() < 2; k++) step();
    start = 1'b0;
    if (rise_q.size() >= 2 && hs_q.size() >= 5) begin
      chk("s6_gap",    32'(rise_q[1] - hs_q[4]),   32'(3));
      chk("s6_period", 32'(rise_q[1] - rise_q[0]), 32'(7));
    end else begin
      chk("s6_frames_seen", 32'(rise_q.size()), 32'(2));
    end
    repeat (10) step();

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      rst   = ($urandom_range(0, 99) < 2);
      start = ($urandom_range(0, 3) == 0);
      ready = ($urandom_range(0, 2) != 0);
      data  = SIZE'($urandom);
      flag  = 1'($urandom);
      step();
    end
    rst = 1'b0; start = 1'b0; ready = 1'b1;
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
